// File: rtl/dsp_mac_sequencer.sv
// ---------------------------------------------------------------------------
// dsp_mac_sequencer
//
// Sequences one DSP48A1-style slice as an 18x18 unsigned multiply-accumulator.
// A job of LEN operand pairs arrives on a valid/ready stream. The pairs are
// forwarded straight to the slice's A/B ports. The 48-bit dot product read
// back from P is then offered on a valid/ready result port.
//
// Expected slice configuration: A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1,
// A0REG=0, B0REG=0, CARRYINSEL="OPMODE5", B_INPUT="DIRECT".
//
// Optional feature (macro MACSEQ_OVF_FLAG_EN): adds output res_ovf. It is a
// sticky flag that records a CARRYOUT from any accumulation of the job.
//
// Ports:
//   clk, RST             clock shared with the slice; synchronous active-high reset
//   start, len, busy     job request (sampled in IDLE), pair count, not-idle flag
//   s_valid/s_ready/s_a/s_b   operand pair stream
//   dsp_a, dsp_b, dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode,
//   dsp_opmode, dsp_cep, dsp_rstp                           slice control
//   dsp_p, dsp_carryout  slice outputs
//   res_valid/res_ready/res_data   result handshake (res_ovf with the macro)
// ---------------------------------------------------------------------------
module dsp_mac_sequencer #(
    parameter int unsigned LEN_W     = 16,
    parameter logic [7:0]  OPM_FIRST = 8'h01,
    parameter logic [7:0]  OPM_ACC   = 8'h09
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_ceopmode,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cep,
    output logic             dsp_rstp,
    input  logic [47:0]      dsp_p,
    input  logic             dsp_carryout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data
`ifdef MACSEQ_OVF_FLAG_EN
    ,
    output logic             res_ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [LEN_W-1:0] cnt_r;
    logic             first_r;       // next accepted pair is the job's first
    logic             tag1_vld_r;    // pair sitting in A1/B1
    logic             tag1_first_r;
    logic             tag2_vld_r;    // pair sitting in M; only its valid bit drives CEP
    logic             rstp_r;        // one-cycle P clear after a job is accepted
    logic             hs_s;
    logic             start_job_s;

    assign hs_s        = s_valid & s_ready;
    assign start_job_s = (state_r == IDLE) & start;

    // State, remaining count and the tag pipe that shadows the slice registers.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            first_r      <= 1'b0;
            tag1_vld_r   <= 1'b0;
            tag1_first_r <= 1'b0;
            tag2_vld_r   <= 1'b0;
            rstp_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            // A missing handshake pushes a bubble, so tag position tracks slice stage.
            tag1_vld_r   <= hs_s;
            tag1_first_r <= hs_s & first_r;
            tag2_vld_r   <= tag1_vld_r;
            rstp_r       <= start_job_s;
            if (start_job_s) begin
                cnt_r   <= len;
                first_r <= 1'b1;
            end else if (hs_s) begin
                cnt_r   <= cnt_r - CNT_ONE;
                first_r <= 1'b0;
            end else begin
                cnt_r   <= cnt_r;
                first_r <= first_r;
            end
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = (len != '0) ? LOAD : DRAIN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (hs_s && (cnt_r == CNT_ONE)) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            DRAIN: begin
                // The product in M (tag2) is written to P on this same edge.
                // With A1/B1 empty, P is final one cycle later.
                if (!tag1_vld_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    assign busy         = (state_r != IDLE);
    assign s_ready      = (state_r == LOAD);
    assign dsp_a        = s_a;
    assign dsp_b        = s_b;
    assign dsp_cea      = hs_s;
    assign dsp_ceb      = hs_s;
    assign dsp_cem      = 1'b1;
    assign dsp_ceopmode = 1'b1;
    // OPMODE is registered inside the slice, so it is selected from tag1 (the
    // pair in A1/B1). It is then in effect in the cycle when that pair's product
    // sits in M.
    assign dsp_opmode   = tag1_first_r ? OPM_FIRST : OPM_ACC;
    assign dsp_cep      = tag2_vld_r;
    assign dsp_rstp     = RST | rstp_r;
    assign res_valid    = (state_r == DONE);
    assign res_data     = dsp_p;

`ifdef MACSEQ_OVF_FLAG_EN
    logic cep_d_r;
    logic ovf_r;

    // Sticky carry-out flag; CARRYOUT is valid the cycle after a P update.
    always_ff @(posedge clk) begin
        if (RST) begin
            cep_d_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            cep_d_r <= tag2_vld_r;
            if (start_job_s) begin
                ovf_r <= 1'b0;
            end else if (cep_d_r & dsp_carryout) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // The last carry lands in the first DONE cycle, so it is forwarded alongside the flag.
    assign res_ovf = res_valid & (ovf_r | (cep_d_r & dsp_carryout));
`else
    logic unused_carryout_s;
    assign unused_carryout_s = dsp_carryout;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dsp_mac_sequencer
//
// Bench for dsp_mac_sequencer. It contains a cycle model of the DSP slice.
// The slice model has a harness override: p_bias replaces Z=0 for the job's
// first product, which lets P start near 2^48. Expected results come from plain
// dot-product arithmetic over the pairs each job sends. Expected latencies come
// from the handshake/start cycle.
// ---------------------------------------------------------------------------
module tb_dsp_mac_sequencer;

    localparam int         LEN_W     = 16;
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             RST;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             s_valid;
    logic             s_ready;
    logic [17:0]      s_a;
    logic [17:0]      s_b;
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic             dsp_cea;
    logic             dsp_ceb;
    logic             dsp_cem;
    logic             dsp_ceopmode;
    logic [7:0]       dsp_opmode;
    logic             dsp_cep;
    logic             dsp_rstp;
    logic [47:0]      dsp_p;
    logic             dsp_carryout;
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_data;
`ifdef MACSEQ_OVF_FLAG_EN
    logic             res_ovf;
`endif

    dsp_mac_sequencer #(
        .LEN_W(LEN_W), .OPM_FIRST(OPM_FIRST), .OPM_ACC(OPM_ACC)
    ) dut (
        .clk(clk), .RST(RST), .start(start), .len(len), .busy(busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb),
        .dsp_cem(dsp_cem), .dsp_ceopmode(dsp_ceopmode), .dsp_opmode(dsp_opmode),
        .dsp_cep(dsp_cep), .dsp_rstp(dsp_rstp), .dsp_p(dsp_p),
        .dsp_carryout(dsp_carryout), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data)
`ifdef MACSEQ_OVF_FLAG_EN
        , .res_ovf(res_ovf)
`endif
    );

    // ---------------- DSP slice model ----------------
    logic [17:0] a1_r = '0;
    logic [17:0] b1_r = '0;
    logic [35:0] m_r = '0;
    logic [7:0]  opm_r = 8'h09;
    logic [47:0] p_r = '0;
    logic        co_r = 1'b0;
    logic [47:0] p_bias = '0;
    logic [47:0] zsel;
    logic [47:0] xsel;
    logic [48:0] dsp_sum;

    always_comb begin
        zsel    = (opm_r[3:2] == 2'b10) ? p_r : p_bias;
        xsel    = (opm_r[1:0] == 2'b01) ? {12'd0, m_r} : 48'd0;
        dsp_sum = {1'b0, zsel} + {1'b0, xsel};
    end

    always @(posedge clk) begin
        if (dsp_cea) a1_r <= dsp_a;
        if (dsp_ceb) b1_r <= dsp_b;
        if (dsp_cem) m_r <= 36'(a1_r) * 36'(b1_r);
        if (dsp_ceopmode) opm_r <= dsp_opmode;
        if (dsp_rstp) begin
            p_r  <= '0;
            co_r <= 1'b0;
        end else if (dsp_cep) begin
            p_r  <= dsp_sum[47:0];
            co_r <= dsp_sum[48];
        end
    end

    assign dsp_p        = p_r;
    assign dsp_carryout = co_r;

    // ---------------- monitor ----------------
    int         cyc = 0;
    int         cep_cnt = 0;
    int         hs_cnt = 0;
    int         rdy_cnt = 0;
    bit         prev_hs = 1'b0;
    logic [7:0] opm_q[$];

    always @(posedge clk) begin
        if (prev_hs) opm_q.push_back(dsp_opmode);
        prev_hs <= s_valid & s_ready;
        if (dsp_cep) cep_cnt <= cep_cnt + 1;
        if (s_ready) rdy_cnt <= rdy_cnt + 1;
        if (s_valid & s_ready) hs_cnt <= hs_cnt + 1;
        cyc <= cyc + 1;
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;
    logic [17:0] qa[$];
    logic [17:0] qb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pair(input logic [17:0] a, input logic [17:0] b);
        qa.push_back(a);
        qb.push_back(b);
    endtask

    task automatic run_job(input int n, input int gap, input bit rand_gap,
                           input int hold, input string tag);
        logic [48:0] acc;
        bit          ovf;
        int          s_c, hs_c, rv_c, g, cep0, hs0, rdy0, opm0;
        acc = (n > 0) ? {1'b0, p_bias} : 49'd0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc = {1'b0, acc[47:0]} + {13'd0, 36'(qa[i]) * 36'(qb[i])};
            if (acc[48]) ovf = 1'b1;
        end
        cep0 = cep_cnt; hs0 = hs_cnt; rdy0 = rdy_cnt; opm0 = opm_q.size();
        start = 1'b1;
        len   = n[LEN_W-1:0];
        s_c   = cyc;
        hs_c  = s_c;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        for (int i = 0; i < n; i++) begin
            g = rand_gap ? int'($urandom_range(gap, 0)) : gap;
            if (i > 0) repeat (g) @(negedge clk);
            s_valid = 1'b1;
            s_a     = qa[i];
            s_b     = qb[i];
            for (int w = 0; w < 8 && !s_ready; w++) @(negedge clk);
            hs_c = cyc;
            @(negedge clk);
            s_valid = 1'b0;
        end
        rv_c = -1;
        for (int w = 0; w < 12; w++) begin
            if (res_valid) begin
                rv_c = cyc;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_latency"}, 64'(rv_c), 64'((n == 0) ? s_c + 2 : hs_c + 3));
        chk({tag, "_data"}, 64'(res_data), 64'(acc[47:0]));
        chk({tag, "_cep_pulses"}, 64'(cep_cnt - cep0), 64'(n));
        chk({tag, "_handshakes"}, 64'(hs_cnt - hs0), 64'(n));
        chk({tag, "_opm_count"}, 64'(opm_q.size() - opm0), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (opm0 + i < opm_q.size())
                chk({tag, "_opmode"}, 64'(opm_q[opm0 + i]), 64'((i == 0) ? OPM_FIRST : OPM_ACC));
        end
        if (n == 0) chk({tag, "_no_ready"}, 64'(rdy_cnt - rdy0), 64'd0);
`ifdef MACSEQ_OVF_FLAG_EN
        chk({tag, "_ovf"}, 64'(res_ovf), 64'(ovf));
`endif
        for (int h = 0; h < hold; h++) begin
            chk({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
            chk({tag, "_hold_data"}, 64'(res_data), 64'(acc[47:0]));
            start = (h == 3);
            len   = 16'd7;
            @(negedge clk);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_idle_after"}, 64'(busy), 64'd0);
        chk({tag, "_valid_after"}, 64'(res_valid), 64'd0);
`ifdef MACSEQ_OVF_FLAG_EN
        chk({tag, "_ovf_after"}, 64'(res_ovf), 64'd0);
`endif
        @(negedge clk);
        chk({tag, "_no_queue"}, 64'(busy), 64'd0);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cep0;
        RST = 1'b1; start = 1'b0; len = '0; res_ready = 1'b0;
        s_valid = 1'b1; s_a = 18'h25A5A; s_b = 18'h1C3C3;
        repeat (3) @(negedge clk);
        chk("rst_rstp", 64'(dsp_rstp), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sready", 64'(s_ready), 64'd0);
        chk("rst_cea", 64'(dsp_cea), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_cep", 64'(dsp_cep), 64'd0);
        chk("rst_opmode", 64'(dsp_opmode), 64'h09);
        chk("rst_cem", 64'(dsp_cem), 64'd1);
        chk("rst_ceopmode", 64'(dsp_ceopmode), 64'd1);
        chk("pass_a", 64'(dsp_a), 64'h25A5A);
        chk("pass_b", 64'(dsp_b), 64'h1C3C3);
        s_valid = 1'b0;
        RST = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_rstp", 64'(dsp_rstp), 64'd0);

        push_pair(18'd1, 18'd2); push_pair(18'd3, 18'd4);
        push_pair(18'd5, 18'd6); push_pair(18'd7, 18'd8);
        run_job(4, 0, 1'b0, 0, "len4");

        push_pair(18'd10, 18'd10); push_pair(18'd20, 18'd20); push_pair(18'd30, 18'd30);
        run_job(3, 2, 1'b0, 0, "len3_gap");

        run_job(0, 0, 1'b0, 0, "len0");

        push_pair(18'd1, 18'd1); push_pair(18'd2, 18'd2);
        run_job(2, 0, 1'b0, 10, "hold");

        // Abort in LOAD after the first of three pairs.
        start = 1'b1; len = 16'd3;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1; s_a = 18'd5; s_b = 18'd5;
        @(negedge clk);
        s_valid = 1'b0; RST = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sready", 64'(s_ready), 64'd0);
        chk("abort_rstp", 64'(dsp_rstp), 64'd1);
        RST = 1'b0;
        cep0 = cep_cnt;
        repeat (4) @(negedge clk);
        chk("abort_no_cep", 64'(cep_cnt - cep0), 64'd0);
        chk("abort_no_result", 64'(res_valid), 64'd0);
        push_pair(18'd3, 18'd3);
        run_job(1, 0, 1'b0, 0, "after_abort");

        for (int j = 0; j < 6; j++) begin
            int n;
            n = int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++)
                push_pair(18'($urandom_range(18'h3FFFF, 0)), 18'($urandom_range(18'h3FFFF, 0)));
            run_job(n, 2, 1'b1, 0, "random");
        end

        for (int i = 0; i < 5; i++) push_pair(18'h3FFFF, 18'h3FFFF);
        run_job(5, 0, 1'b0, 0, "max_operands");

        // P preloaded just below 2^48: the sum wraps and produces a carry.
        p_bias = 48'hFFFF_FFFF_FFFE;
        push_pair(18'd1, 18'd1); push_pair(18'd2, 18'd2);
        run_job(2, 0, 1'b0, 0, "wrap");
        p_bias = '0;
        push_pair(18'd2, 18'd3); push_pair(18'd4, 18'd5);
        run_job(2, 1, 1'b0, 0, "clean");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Controller that sequences one DSP48A1-style slice as an 18x18 multiply-accumulator.
- Accepts a job of LEN operand pairs over a valid/ready stream and drives the slice's A/B inputs, clock enables, OPMODE and RSTP.
- Tracks the slice pipeline (A1/B1 reg, M reg, P reg, registered OPMODE) and presents the 48-bit dot product on a valid/ready result port.
- Sits between a data mover and the DSP instance; the DSP is configured A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYINSEL="OPMODE5", B_INPUT="DIRECT".

Parameters:
- LEN_W, 16, width of the job length.
- OPM_FIRST, 8'h01, OPMODE for the first product of a job: X=M, Z=0, add, carry 0.
- OPM_ACC, 8'h09, OPMODE for later products: X=M, Z=P, add, carry 0.

Ports:
- clk  in  1  rising-edge clock, shared with the DSP slice.
- RST  in  1  synchronous, active-high reset.
- start  in  1  job request, sampled only in IDLE.
- len  in  LEN_W  number of operand pairs, sampled with start.
- busy  out  1  high in any state except IDLE.
- s_valid  in  1  operand pair valid.
- s_ready  out  1  sequencer accepts an operand pair.
- s_a  in  18  operand A.
- s_b  in  18  operand B.
- dsp_a  out  18  to DSP A; equals s_a combinationally.
- dsp_b  out  18  to DSP B; equals s_b combinationally.
- dsp_cea  out  1  to CEA; equals s_valid & s_ready.
- dsp_ceb  out  1  to CEB; same as dsp_cea.
- dsp_cem  out  1  to CEM; constant 1.
- dsp_ceopmode  out  1  to CEOPMODE; constant 1.
- dsp_opmode  out  8  to OPMODE.
- dsp_cep  out  1  to CEP.
- dsp_rstp  out  1  to RSTP.
- dsp_p  in  48  from DSP P.
- dsp_carryout  in  1  from DSP CARRYOUT; used only with the optional feature.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  48  equals dsp_p; meaningful only while res_valid=1.

Behaviour:
- States: IDLE, LOAD, DRAIN, DONE. A 2-entry tag pipe follows the slice: tag1 = {vld, first} for the pair in A1/B1; tag2 = the same for the pair in M.
- Reset: state=IDLE, tags cleared, counter=0, s_ready=0, res_valid=0, dsp_cep=0, dsp_opmode=OPM_ACC, dsp_rstp=1 while RST is high.
- IDLE:
  - start=1 and len!=0: latch len into the remaining-count register, assert dsp_rstp for 1 cycle, go to LOAD.
  - start=1 and len==0: assert dsp_rstp for 1 cycle, go to DRAIN with an empty pipe. P=0 becomes the result.
  - start=0: stay in IDLE.
- LOAD:
  - s_ready=1. Each handshake (s_valid & s_ready) decrements the count and pushes tag {1, first}; first=1 only for the job's first pair.
  - No handshake pushes tag {0, x}, a bubble.
  - The handshake on the last pair moves to DRAIN.
- OPMODE timing:
  - dsp_opmode = tag1.first ? OPM_FIRST : OPM_ACC, driven one cycle after the operands' handshake so the registered OPMODE aligns with the M stage.
  - dsp_cep = tag2.vld. Bubbles never update P.
  - Product of a pair accepted at cycle t is in P at cycle t+3.
- DRAIN: s_ready=0. When both tags are empty and the last CEP has retired, go to DONE. res_valid rises exactly 3 cycles after the last handshake, or 2 cycles after start when len==0.
- DONE:
  - res_valid=1. dsp_cep=0, so P holds.
  - res_valid & res_ready → IDLE.
  - res_valid is held, and res_data stays stable, until accepted.
- start while busy=1 is ignored; no queueing.
- Arithmetic: unsigned 18x18 products, 48-bit modulo-2^48 accumulation; wrap is silent without the optional feature.
- len maximum is 2^LEN_W-1; the count does not wrap.
- RST mid-job: abort immediately, return to IDLE, dsp_rstp=1 clears P, no result is produced, and partial operands are discarded.

Optional Feature:
- Macro: MACSEQ_OVF_FLAG_EN.
- With the macro defined:
  - Adds output res_ovf (1 bit).
  - A sticky flag is cleared at job start and set when dsp_carryout=1 in the cycle after any dsp_cep=1.
  - res_ovf reflects the flag while res_valid=1 and is 0 otherwise.
- Without the macro: the port and logic are absent, and dsp_carryout is unused.

Test Plan:
- len=4, pairs (1,2),(3,4),(5,6),(7,8), s_valid held high → res_data=100, res_valid 3 cycles after the 4th handshake; OPMODE sequence 01,09,09,09.
- len=3, pairs (10,10),(20,20),(30,30), s_valid low for 2 cycles between each pair → res_data=1400; dsp_cep pulses exactly 3 times.
- len=0 → res_valid after 2 cycles with res_data=0; s_ready never asserted.
- Job len=2 result 48'h5 held with res_ready=0 for 10 cycles → res_valid and res_data stable; start pulses ignored; IDLE after accept.
- RST asserted mid-LOAD after 1 of 3 pairs, then new job len=1 with (3,3) → res_data=9; no residue from the aborted job.
- MACSEQ_OVF_FLAG_EN defined, len=2 with values driving the accumulator past 2^48 (P preloaded near 2^48-1 by a prior DSP test harness override) → res_ovf=1; the following clean job gives res_ovf=0.
